// File: rtl/rx_trena_7e1.sv
// rx_trena_7e1: 7E1 serial receiver that assembles a 3-digit BCD measurement
// sent as units, tens, hundreds followed by a '#' terminator.
module rx_trena_7e1 #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro_paridade,
    output logic        erro_quadro,
    output logic        erro_formato,
    output logic [3:0]  db_estado
);

    localparam int unsigned CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned HALF_LAST = BAUD_DIV / 2 - 1;
    localparam int unsigned FULL_LAST = BAUD_DIV - 1;
    localparam logic [6:0]  HASH      = 7'h23;

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        START    = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        STOP     = 3'd4,
        FIM      = 3'd5
    } bit_state_t;

    typedef enum logic [2:0] {
        D0   = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        TERM = 3'd3,
        SINC = 3'd4
    } frame_state_t;

    logic sync_a;
    logic sync_b;
    logic sync_prev;

    bit_state_t   bit_state;
    frame_state_t frame_state;

    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       char_code;
    logic             char_par;
    logic             char_perr;
    logic             char_ferr;
    logic [11:0]      shadow;

    logic char_strobe;
    logic is_digit;
    logic is_hash;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; never reset.
    always_ff @(posedge clock) begin
        sync_a    <= entrada_serial;
        sync_b    <= sync_a;
        sync_prev <= sync_b;
    end

    // Bit-level FSM: start detection with glitch rejection, mid-bit sampling.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_state <= INICIAL;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            char_code <= '0;
            char_par  <= 1'b0;
            char_perr <= 1'b0;
            char_ferr <= 1'b0;
        end else begin
            case (bit_state)
                INICIAL: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (sync_prev && !sync_b) begin
                        bit_state <= START;
                    end
                end
                START: begin
                    if (baud_cnt == CNT_W'(HALF_LAST)) begin
                        baud_cnt  <= '0;
                        bit_state <= sync_b ? INICIAL : DADOS;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DADOS: begin
                    if (baud_cnt == CNT_W'(FULL_LAST)) begin
                        baud_cnt  <= '0;
                        char_code <= {sync_b, char_code[6:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd6) begin
                            bit_state <= PARIDADE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARIDADE: begin
                    if (baud_cnt == CNT_W'(FULL_LAST)) begin
                        baud_cnt  <= '0;
                        char_par  <= sync_b;
                        bit_state <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == CNT_W'(FULL_LAST)) begin
                        baud_cnt  <= '0;
                        char_perr <= (^char_code) ^ char_par;
                        char_ferr <= !sync_b;
                        bit_state <= FIM;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                FIM: begin
                    bit_state <= INICIAL;
                end
                default: begin
                    bit_state <= INICIAL;
                end
            endcase
        end
    end

    // Character strobe and classification of the received code.
    assign char_strobe = (bit_state == FIM);
    assign is_digit    = (char_code[6:4] == 3'b011) && (char_code[3:0] <= 4'd9);
    assign is_hash     = (char_code == HASH);
    assign db_estado   = 4'(bit_state);

    // Frame-level FSM: digit assembly into the shadow register, error pulses, resync.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_state   <= D0;
            shadow        <= '0;
            medida        <= '0;
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_formato  <= 1'b0;
        end else begin
            pronto        <= 1'b0;
            erro_paridade <= 1'b0;
            erro_quadro   <= 1'b0;
            erro_formato  <= 1'b0;
            if (char_strobe) begin
                if (char_perr) begin
                    erro_paridade <= 1'b1;
                    frame_state   <= SINC;
                end else if (char_ferr) begin
                    erro_quadro <= 1'b1;
                    frame_state <= SINC;
                end else begin
                    case (frame_state)
                        D0, D1, D2: begin
                            if (is_digit) begin
                                case (frame_state)
                                    D0:      begin shadow[3:0]  <= char_code[3:0]; frame_state <= D1;   end
                                    D1:      begin shadow[7:4]  <= char_code[3:0]; frame_state <= D2;   end
                                    default: begin shadow[11:8] <= char_code[3:0]; frame_state <= TERM; end
                                endcase
                            end else if (is_hash) begin
                                erro_formato <= 1'b1;
                                frame_state  <= D0;
                            end else begin
                                erro_formato <= 1'b1;
                                frame_state  <= SINC;
                            end
                        end
                        TERM: begin
                            if (is_hash) begin
                                medida      <= shadow;
                                pronto      <= 1'b1;
                                frame_state <= D0;
                            end else begin
                                erro_formato <= 1'b1;
                                frame_state  <= SINC;
                            end
                        end
                        SINC: begin
                            if (is_hash) begin
                                frame_state <= D0;
                            end
                        end
                        default: begin
                            frame_state <= D0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
